// File: rtl/lif_pkg.sv
// Shared definitions for the LIF spike-rate readout path: default sizes,
// readout state encoding and a channel-index width helper.
package lif_pkg;

    localparam int N_CH_DEF  = 2;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_t;

    // Channel index needs at least one bit even for a single channel.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// One spike channel: rising-edge detector feeding a saturating counter that
// clears when the window closes.
module spike_edge_counter
    import lif_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_spike,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt_final
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_spk_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_edge      = i_spike & ~r_spk_q;
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? CNT_MAX
                                            : r_cnt + {{(CNT_W-1){1'b0}}, w_edge};
    // Includes an edge arriving on the close cycle itself.
    assign o_cnt_final = w_cnt_inc;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values;
    // blocking would let r_spk_q update before w_edge is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spk_q <= 1'b0;
            r_cnt   <= '0;
        end else if (i_en) begin
            r_spk_q <= i_spike;
            r_cnt   <= i_clr ? '0 : w_cnt_inc;
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Counts spike edges per channel over a programmable window, snapshots the
// counts at window close and streams them out one channel per valid/ready beat.
module spike_rate_monitor
    import lif_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int WIN_W = WIN_W_DEF,
    localparam int CH_W  = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [CNT_W-1:0] out_data,
    output logic             win_tick,
    output logic             overrun
);

    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  CH_ONE  = {{(CH_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    // ---------------- window timer ----------------
    logic             r_started;
    logic [WIN_W-1:0] r_rem;
    logic [WIN_W-1:0] w_len_m1;
    logic [WIN_W-1:0] w_rem_eff;
    logic             w_close;

    assign w_len_m1  = (win_len == '0) ? '0 : win_len - WIN_ONE;
    // Before the first en cycle the window has not been loaded yet, so the
    // first en cycle behaves as cycle one of a freshly loaded window.
    assign w_rem_eff = r_started ? r_rem : w_len_m1;
    assign w_close   = en & (w_rem_eff == '0);
    assign win_tick  = w_close;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started <= 1'b0;
            r_rem     <= '0;
        end else if (en) begin
            r_started <= 1'b1;
            r_rem     <= w_close ? w_len_m1 : w_rem_eff - WIN_ONE;
        end
    end

    // ---------------- per-channel counters ----------------
    logic [CNT_W-1:0] w_final [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_edge_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_en        (en),
            .i_spike     (spike_in[g]),
            .i_clr       (w_close),
            .o_cnt_final (w_final[g])
        );
    end

    // ---------------- snapshot + readout ----------------
    rd_state_t        r_state;
    logic             r_pending;
    logic [CNT_W-1:0] r_shadow [N_CH];
    logic [CH_W-1:0]  r_out_ch;
    logic [CNT_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;

    logic             w_accept;
    logic             w_last_accept;
    logic             w_busy;
    logic             w_load;
    logic [CH_W-1:0]  w_next_ch;

    assign w_accept      = r_out_valid & out_ready;
    assign w_last_accept = w_accept & (r_out_ch == LAST_CH);
    // A snapshot waiting to be presented is just as unread as one being sent.
    assign w_busy        = r_pending | ((r_state == SEND) & ~w_last_accept);
    assign w_load        = w_close & ~w_busy;
    assign w_next_ch     = r_out_ch + CH_ONE;

    // NOTE: the shadow bank has no reset; it is only ever read after a load,
    // and every output it feeds is itself reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= w_final[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_close && w_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_state     <= SEND;
                        r_pending   <= 1'b0;
                        r_out_ch    <= '0;
                        r_out_data  <= r_shadow[0];
                        r_out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_last_accept) begin
                        r_state     <= IDLE;
                        r_out_ch    <= '0;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_ch   <= w_next_ch;
                        r_out_data <= r_shadow[w_next_ch];
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: expected readout words are queued as
// stimulus is driven and popped as the DUT hands them over.
module tb_spike_rate_monitor;

    typedef struct packed {
        logic [0:0] ch;
        logic [7:0] data;
    } word_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  spike_in;
    logic [15:0] win_len;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [7:0]  out_data;
    logic        win_tick;
    logic        overrun;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];
    int    tick_q[$];
    int    tick_abs_q[$];
    int    en_cyc  = 0;
    int    abs_cyc = 0;

    spike_rate_monitor u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .spike_in  (spike_in),
        .win_len   (win_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .win_tick  (win_tick),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [0:0] ch, input logic [7:0] data);
        word_t w;
        w.ch   = ch;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // One clock cycle with the given inputs, returning just after the edge.
    task automatic step(input logic e, input logic [1:0] s);
        en       = e;
        spike_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        spike_in = 2'b00;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard side: observes ticks and accepted words at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            en_cyc  = 0;
            abs_cyc = 0;
            tick_q.delete();
            tick_abs_q.delete();
        end else begin
            abs_cyc++;
            if (en) en_cyc++;
            if (win_tick) begin
                tick_q.push_back(en_cyc);
                tick_abs_q.push_back(abs_cyc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("word_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("word_ch", 32'(out_ch), 32'(e.ch));
                    check("word_data", 32'(out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        spike_in  = 2'b00;
        win_len   = 16'd10;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_ch",      32'(out_ch),    32'd0);
        check("rst_data",    32'(out_data),  32'd0);
        check("rst_tick",    32'(win_tick),  32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        rst = 1'b0;

        // 1: three single-cycle pulses on ch0 in a 10-cycle window
        win_len   = 16'd10;
        out_ready = 1'b1;
        push(1'b0, 8'd3);
        push(1'b1, 8'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, (i == 2 || i == 4 || i == 6) ? 2'b01 : 2'b00);
        end
        check("t1_lat_cycle1", 32'(out_valid), 32'd0);
        step(1'b0, 2'b00);
        check("t1_lat_cycle2", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00);
        check("t1_tick_n",  32'(tick_q.size()), 32'd1);
        check("t1_tick_at", 32'(tick_q[0]),     32'd10);
        check("t1_drained", 32'(exp_q.size()),  32'd0);
        check("t1_overrun", 32'(overrun),       32'd0);
        check("t1_idle",    32'(out_valid),     32'd0);

        // 2: ch0 held high for 25 cycles counts once
        do_reset();
        win_len = 16'd50;
        push(1'b0, 8'd1);
        push(1'b1, 8'd0);
        for (int i = 1; i <= 50; i++) step(1'b1, (i <= 25) ? 2'b01 : 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
        check("t2_tick_at", 32'(tick_q[0]),    32'd50);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3: ch1 toggling for 1000 cycles saturates at 255
        do_reset();
        win_len = 16'd1000;
        push(1'b0, 8'd0);
        push(1'b1, 8'd255);
        for (int i = 1; i <= 1000; i++) step(1'b1, {1'(i % 2), 1'b0});
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
        check("t3_tick_at", 32'(tick_q[0]),    32'd1000);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: consumer stalled across two closes
        do_reset();
        win_len   = 16'd4;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, {1'(i == 2), 1'(i == 1 || i == 5 || i == 7)});
        end
        check("t4_overrun", 32'(overrun),   32'd1);
        check("t4_valid",   32'(out_valid), 32'd1);
        check("t4_ch_held", 32'(out_ch),    32'd0);
        check("t4_data",    32'(out_data),  32'd1);
        step(1'b0, 2'b00);
        check("t4_data_stable", 32'(out_data), 32'd1);
        push(1'b0, 8'd1);
        push(1'b1, 8'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
        check("t4_drained",  32'(exp_q.size()), 32'd0);
        check("t4_no_extra", 32'(out_valid),    32'd0);
        check("t4_sticky",   32'(overrun),      32'd1);

        // 5: edge on the close cycle and on the next cycle
        do_reset();
        win_len   = 16'd4;
        out_ready = 1'b1;
        push(1'b0, 8'd1);
        push(1'b1, 8'd0);
        push(1'b0, 8'd0);
        push(1'b1, 8'd1);
        for (int i = 1; i <= 8; i++) step(1'b1, {1'(i == 5), 1'(i == 4)});
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
        check("t5_tick_n",   32'(tick_q.size()), 32'd2);
        check("t5_tick0",    32'(tick_q[0]),     32'd4);
        check("t5_tick1",    32'(tick_q[1]),     32'd8);
        check("t5_drained",  32'(exp_q.size()),  32'd0);
        check("t5_overrun",  32'(overrun),       32'd0);

        // 6a: win_len=0 closes every en cycle
        do_reset();
        win_len   = 16'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
        check("t6a_tick_n", 32'(tick_q.size()), 32'd3);
        check("t6a_tick2",  32'(tick_q[2]),     32'd3);

        // 6b: en low for 5 cycles stretches a 6-cycle window to 11 clocks
        do_reset();
        win_len = 16'd6;
        for (int i = 1; i <= 11; i++) step((i <= 3 || i >= 9) ? 1'b1 : 1'b0, 2'b00);
        check("t6b_tick_n",   32'(tick_q.size()),  32'd1);
        check("t6b_tick_en",  32'(tick_q[0]),      32'd6);
        check("t6b_tick_abs", 32'(tick_abs_q[0]),  32'd11);

        // 6c: reset while a snapshot is being presented
        do_reset();
        win_len = 16'd2;
        for (int i = 1; i <= 3; i++) step(1'b1, {1'b0, 1'(i != 2)});
        check("t6c_sending", 32'(out_valid), 32'd1);
        check("t6c_data",    32'(out_data),  32'd1);
        rst = 1'b1;
        #1;
        check("t6c_rst_valid",   32'(out_valid), 32'd0);
        check("t6c_rst_data",    32'(out_data),  32'd0);
        check("t6c_rst_overrun", 32'(overrun),   32'd0);
        en       = 1'b0;
        spike_in = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        push(1'b0, 8'd0);
        push(1'b1, 8'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
        check("t6c_post_tick", 32'(tick_q.size()), 32'd1);
        check("t6c_drained",   32'(exp_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
